// File: rtl/up_counter_mod.sv
// up_counter_mod
//   Parameterised modulo-MODULUS up counter with enable, synchronous load,
//   terminal-count and wrap indication, and an optional one-shot mode that
//   stops at the terminal count.
//
//   Parameters
//     WIDTH    counter width in bits
//     MODULUS  count range 0..MODULUS-1, with 2 <= MODULUS <= 2**WIDTH
//
//   Ports
//     clk       in   clock, rising edge
//     rst       in   synchronous, active-high reset
//     en        in   count enable (ignored in DONE)
//     load      in   synchronous load strobe, beats en
//     load_val  in   value to load, clamped to MODULUS-1
//     oneshot   in   1 = stop at terminal count, 0 = wrap
//     count     out  current count (registered)
//     tc        out  count == MODULUS-1, decoded from the count register only
//     wrap      out  one-cycle pulse in the first cycle of 0 after a wrap
//     done      out  high while stopped in DONE
//     wraps     out  saturating wrap event counter
//
//   Build option
//     UP_COUNTER_WRAP_CNT_EN  when defined, wraps is an 8-bit saturating
//                             register cleared only by rst; otherwise it is
//                             tied to zero.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   RUN   | counting when en=1, holding when en=0
//   DONE  | one-shot finished at MODULUS-1; exits only on load or rst

module up_counter_mod #(
    parameter int WIDTH   = 3,
    parameter int MODULUS = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             oneshot,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             done,
    output logic [7:0]       wraps
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q,  wrap_d;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        wrap_d  = 1'b0;
        if (load) begin
            count_d = (load_val > MAX_CNT) ? MAX_CNT : load_val;
            state_d = ST_RUN;
        end else if ((state_q == ST_RUN) && en) begin
            // Compare-and-clear so a non-power-of-two modulus wraps correctly.
            if (count_q == MAX_CNT) begin
                if (oneshot) begin
                    state_d = ST_DONE;
                end else begin
                    count_d = '0;
                    wrap_d  = 1'b1;
                end
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count = count_q;
    assign tc    = (count_q == MAX_CNT);
    assign wrap  = wrap_q;
    assign done  = (state_q == ST_DONE);

`ifdef UP_COUNTER_WRAP_CNT_EN
    logic [7:0] wraps_q, wraps_d;

    // wrap_d marks the edge on which the count returns to zero.
    always_comb begin
        wraps_d = wraps_q;
        if (wrap_d && (wraps_q != 8'hFF)) begin
            wraps_d = wraps_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wraps_q <= 8'h00;
        end else begin
            wraps_q <= wraps_d;
        end
    end

    assign wraps = wraps_q;
`else
    assign wraps = 8'h00;
`endif

endmodule

// File: tb/tb_up_counter_mod.sv
module tb_up_counter_mod;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       load = 1'b0;
    logic [2:0] load_val = 3'd0;
    logic       oneshot = 1'b0;

    logic [2:0] count, count6;
    logic [0:0] count2;
    logic       tc, wrap, done;
    logic       tc6, wrap6, done6;
    logic       tc2, wrap2, done2;
    logic [7:0] wraps, wraps6, wraps2;

    int errors = 0;
    int checks = 0;
    int exp_wraps = 0;

    always #5 clk = ~clk;

    up_counter_mod #(.WIDTH(3), .MODULUS(8)) dut (
        .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
        .oneshot(oneshot), .count(count), .tc(tc), .wrap(wrap), .done(done),
        .wraps(wraps)
    );

    up_counter_mod #(.WIDTH(3), .MODULUS(6)) dut6 (
        .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
        .oneshot(oneshot), .count(count6), .tc(tc6), .wrap(wrap6), .done(done6),
        .wraps(wraps6)
    );

    up_counter_mod #(.WIDTH(1), .MODULUS(2)) dut2 (
        .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val[0:0]),
        .oneshot(oneshot), .count(count2), .tc(tc2), .wrap(wrap2), .done(done2),
        .wraps(wraps2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int wraps_exp(input int n);
`ifdef UP_COUNTER_WRAP_CNT_EN
        return (n > 255) ? 255 : n;
`else
        return 0;
`endif
    endfunction

    initial begin
        // Reset held with en=1
        rst = 1'b1; en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("rst_count", count, 0);
            chk("rst_tc", tc, 0);
            chk("rst_wrap", wrap, 0);
            chk("rst_done", done, 0);
            chk("rst_wraps", wraps, 0);
        end
        chk("rst_count6", count6, 0);
        chk("rst_count2", count2, 0);

        // Free run, wrap continuously
        rst = 1'b0; en = 1'b1; oneshot = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (i == 8) exp_wraps++;
            chk("run_count", count, i % 8);
            chk("run_tc", tc, ((i % 8) == 7) ? 1 : 0);
            chk("run_wrap", wrap, (i == 8) ? 1 : 0);
            chk("run_done", done, 0);
            chk("run_wraps", wraps, wraps_exp(exp_wraps));
            chk("m2_count", count2, i % 2);
            chk("m2_wrap", wrap2, ((i % 2) == 0) ? 1 : 0);
        end

        // Load priority over enable
        step();
        chk("ld_pre", count, 3);
        load = 1'b1; load_val = 3'd5; en = 1'b1;
        step();
        chk("ld_count5", count, 5);
        chk("ld_wrap5", wrap, 0);
        load = 1'b0;
        step();
        chk("ld_count6", count, 6);
        step();
        chk("ld_count7", count, 7);
        chk("ld_tc7", tc, 1);
        load = 1'b1; load_val = 3'd7;
        step();
        chk("ld_at_tc_count", count, 7);
        chk("ld_at_tc_wrap", wrap, 0);
        chk("ld_at_tc_done", done, 0);
        chk("ld_at_tc_wraps", wraps, wraps_exp(exp_wraps));
        load = 1'b0; en = 1'b0;
        step();
        chk("hold_count", count, 7);
        chk("hold_tc", tc, 1);

        // One-shot from zero
        load = 1'b1; load_val = 3'd0;
        step();
        chk("os_start", count, 0);
        load = 1'b0; en = 1'b1; oneshot = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step();
            chk("os_count", count, (i < 7) ? i : 7);
            chk("os_done", done, (i >= 8) ? 1 : 0);
            chk("os_wrap", wrap, 0);
        end
        load = 1'b1; load_val = 3'd2;
        step();
        chk("os_exit_count", count, 2);
        chk("os_exit_done", done, 0);
        chk("os_wraps", wraps, wraps_exp(exp_wraps));

        // MODULUS=6: clamp, wrap, one-shot, reset out of DONE
        load = 1'b0; en = 1'b0; oneshot = 1'b0; rst = 1'b1;
        step();
        chk("m6_rst", count6, 0);
        rst = 1'b0; load = 1'b1; load_val = 3'd7;
        step();
        chk("m6_clamp", count6, 5);
        chk("m6_tc", tc6, 1);
        chk("m6_nowrap", wrap6, 0);
        load = 1'b0; en = 1'b1;
        step();
        chk("m6_wrap_count", count6, 0);
        chk("m6_wrap", wrap6, 1);
        chk("m6_wrap_tc", tc6, 0);
        oneshot = 1'b1;
        repeat (5) step();
        chk("m6_os_count", count6, 5);
        chk("m6_os_run", done6, 0);
        chk("m6_os_wrap_gone", wrap6, 0);
        step();
        chk("m6_os_done", done6, 1);
        step();
        chk("m6_done_hold", count6, 5);
        chk("m6_done_still", done6, 1);
        rst = 1'b1;
        step();
        chk("m6_rst_count", count6, 0);
        chk("m6_rst_done", done6, 0);
        chk("m6_rst_tc", tc6, 0);
        chk("rst_in_done_count", count, 0);
        chk("rst_in_done_done", done, 0);

        // Long run: wraps saturates when the counter is built in
        rst = 1'b0; en = 1'b1; oneshot = 1'b0; load = 1'b0;
        repeat (80) @(posedge clk);
        #1;
        chk("wraps_10", wraps, wraps_exp(10));
        repeat (2020) @(posedge clk);
        #1;
        chk("wraps_sat", wraps, wraps_exp(2100 / 8));
        load = 1'b1; load_val = 3'd3;
        step();
        chk("wraps_load_count", count, 3);
        chk("wraps_after_load", wraps, wraps_exp(2100 / 8));
        load = 1'b0; rst = 1'b1;
        step();
        chk("wraps_rst", wraps, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
